// File: rtl/mips_muldiv.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, 32 iterations plus a fix-up cycle.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [4:0]   cnt;
  logic [1:0]   op_r;
  logic         sign_a;
  logic         sign_b;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic [W-1:0] divisor;
  logic [W-1:0] quo;
  logic [W-1:0] orig_rs;
  logic [2*W-1:0] acc;
  logic [W:0]   rem;

  logic         neg_a;
  logic         neg_b;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic [W:0]   mul_sum;
  logic [W:0]   rem_sh;
  logic         rem_ge;
  logic [2*W-1:0] prod;
  logic [W-1:0] q_fix;
  logic [W-1:0] r_fix;
  logic         is_div;
  logic         is_sgn;

  // Operand conditioning and per-iteration datapath
  always_comb begin
    is_div  = op_r[1];
    is_sgn  = op_r[0];
    neg_a   = op[0] & rs_data[W-1];
    neg_b   = op[0] & rt_data[W-1];
    mag_a   = neg_a ? -rs_data : rs_data;
    mag_b   = neg_b ? -rt_data : rt_data;
    mul_sum = {1'b0, acc[2*W-1:W]}
            + (mplier[0] ? {1'b0, mcand}
                         : {(W+1){1'b0}});
    rem_sh  = {rem[W-1:0], quo[W-1]};
    rem_ge  = rem_sh >= {1'b0, divisor};
    prod    = (is_sgn && (sign_a ^ sign_b))
            ? -acc : acc;
    q_fix   = (is_sgn && (sign_a ^ sign_b))
            ? -quo : quo;
    r_fix   = (is_sgn && sign_a)
            ? -rem[W-1:0] : rem[W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, iteration counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      op_r        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      divisor     <= '0;
      quo         <= '0;
      orig_rs     <= '0;
      acc         <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_r        <= op;
            sign_a      <= neg_a;
            sign_b      <= neg_b;
            mcand       <= mag_a;
            mplier      <= mag_b;
            divisor     <= mag_b;
            quo         <= mag_a;
            orig_rs     <= rs_data;
            acc         <= '0;
            rem         <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            rem <= rem_ge
                 ? rem_sh - {1'b0, divisor}
                 : rem_sh;
            quo <= {quo[W-2:0], rem_ge};
          end else begin
            acc    <= {mul_sum, acc[W-1:1]};
            mplier <= mplier >> 1;
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod[2*W-1:W];
            lo <= prod[W-1:0];
          end else if (divisor == '0) begin
            hi          <= orig_rs;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv.
// Vector table plus hand sequences for start-ignore and reset abort.
module tb_mips_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t tv[12];

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .rs_data(rs),
    .rt_data(rt),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Waits for done; n is the edge count from E0, -1 on timeout.
  task automatic wait_done(input string nm, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 16) begin
        chk({nm, "_hold_hi"}, 64'(hi), 64'(prev_hi));
        chk({nm, "_hold_lo"}, 64'(lo), 64'(prev_lo));
      end
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string nm, input int n,
                              input logic [31:0] eh,
                              input logic [31:0] el,
                              input logic ed);
    chk({nm, "_latency"}, 64'(n), 64'd33);
    chk({nm, "_busy_done"}, 64'(busy), 64'd0);
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    chk({nm, "_dbz"}, 64'(dbz), 64'(ed));
    prev_hi = eh;
    prev_lo = el;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    start = 1'b1;
    op    = v.op;
    rs    = v.a;
    rt    = v.b;
    @(posedge clk); #1;
    start = 1'b0;
    rs    = $urandom;
    rt    = $urandom;
    chk({v.name, "_busy_e0"}, 64'(busy), 64'd1);
    chk({v.name, "_dbz_clr"}, 64'(dbz), 64'd0);
    wait_done(v.name, n);
    check_result(v.name, n, v.hi, v.lo, v.dbz);
    @(posedge clk); #1;
    chk({v.name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    tv[0]  = '{"multu_max", 2'b00, 32'hFFFFFFFF,
               32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[1]  = '{"mult_m3x7", 2'b01, 32'hFFFFFFFD,
               32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[2]  = '{"mult_min2", 2'b01, 32'h80000000,
               32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tv[3]  = '{"divu_100_7", 2'b10, 32'd100,
               32'd7, 32'd2, 32'd14, 1'b0};
    tv[4]  = '{"div_m7_2", 2'b11, 32'hFFFFFFF9,
               32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[5]  = '{"div_ovf", 2'b11, 32'h80000000,
               32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tv[6]  = '{"divu_5_0", 2'b10, 32'd5,
               32'd0, 32'd5, 32'hFFFFFFFF, 1'b1};
    tv[7]  = '{"multu_2x3", 2'b00, 32'd2,
               32'd3, 32'd0, 32'd6, 1'b0};
    tv[8]  = '{"div_7_m2", 2'b11, 32'd7,
               32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0};
    tv[9]  = '{"div_m7_m2", 2'b11, 32'hFFFFFFF9,
               32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 1'b0};
    tv[10] = '{"div_neg_0", 2'b11, 32'hFFFFFFF9,
               32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tv[11] = '{"multu_shift", 2'b00, 32'h12345678,
               32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    rs    = '0;
    rt    = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) run_vec(tv[i]);

    // Start pulses while busy are ignored.
    start = 1'b1; op = 2'b00; rs = 32'd3; rt = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy_e0", 64'(busy), 64'd1);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
      if (i == 5 || i == 20) begin
        start = 1'b1; op = 2'b10;
        rs = 32'd100; rt = 32'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_result("ign", n, 32'd0, 32'd12, 1'b0);

    // Start during the done cycle is accepted.
    start = 1'b1; op = 2'b00; rs = 32'd5; rt = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_done_low", 64'(done), 64'd0);
    wait_done("b2b", n);
    check_result("b2b", n, 32'd0, 32'd30, 1'b0);

    // Asynchronous reset mid-divide aborts the operation.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11;
    rs = 32'hFFFFFF9C; rt = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("arst_no_done", 64'(seen), 64'd0);

    run_vec('{"divu_9_3", 2'b10, 32'd9,
              32'd3, 32'd0, 32'd3, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
